mux2_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one N-bit 2:1 mux datapath, for example between instruction fetch and data access on a single memory port.
- Grants ownership with a REQ/GNT/DONE handshake and drives the mux select.
- Forwards the owner's operand to Y.
- Enforces a hold-time limit so one requester cannot starve the other.

---
 rtl/mux2_arbiter.sv | 120 ++++++++++++
 tb/tb_mux2_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 mux, with a
// REQ/GNT/DONE handshake and a bounded hold time per grant.
module mux2_arbiter #(
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_req0,
    input  logic         i_req1,
    input  logic         i_done0,
    input  logic         i_done1,
    input  logic [N-1:0] i_d0,
    input  logic [N-1:0] i_d1,
    output logic         o_gnt0,
    output logic         o_gnt1,
    output logic         o_sel,
    output logic [N-1:0] o_y,
    output logic         o_busy,
    output logic         o_timeout_err
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e        r_state, w_state_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic          r_last, w_last_d;
    logic          r_sel, w_sel_d;
    logic          r_err, w_err_d;
    logic          w_limit;
    logic          w_rel0;
    logic          w_rel1;

    assign w_limit = (TIMEOUT != 0) && (r_cnt == CNT_LIMIT);
    assign w_rel0  = i_done0 | ~i_req0 | w_limit;
    assign w_rel1  = i_done1 | ~i_req1 | w_limit;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_last_d  = r_last;
        w_sel_d   = r_sel;
        w_err_d   = 1'b0;

        unique case (r_state)
            StIdle: begin
                // Under contention the requester that did not own last wins.
                if (i_req0 && (!i_req1 || r_last)) begin
                    w_state_d = StOwn0;
                end else if (i_req1) begin
                    w_state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (w_rel0) begin
                    w_err_d   = w_limit & ~i_done0 & i_req0;
                    w_state_d = i_req1 ? StOwn1 : StIdle;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            StOwn1: begin
                if (w_rel1) begin
                    w_err_d   = w_limit & ~i_done1 & i_req1;
                    w_state_d = i_req0 ? StOwn0 : StIdle;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (w_state_d == StOwn0 && r_state != StOwn0) begin
            w_last_d = 1'b0;
            w_cnt_d  = '0;
        end
        if (w_state_d == StOwn1 && r_state != StOwn1) begin
            w_last_d = 1'b1;
            w_cnt_d  = '0;
        end

        if (w_state_d == StOwn0) begin
            w_sel_d = 1'b0;
        end else if (w_state_d == StOwn1) begin
            w_sel_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_last  <= w_last_d;
            r_sel   <= w_sel_d;
            r_err   <= w_err_d;
        end
    end

    assign o_gnt0        = (r_state == StOwn0);
    assign o_gnt1        = (r_state == StOwn1);
    assign o_busy        = o_gnt0 | o_gnt1;
    assign o_sel         = r_sel;
    assign o_timeout_err = r_err;
    assign o_y           = r_sel ? i_d1 : i_d0;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: expected grant/select/error values are queued
// when stimulus is driven and compared one cycle later.
module tb_mux2_arbiter;

    localparam int unsigned N = 32;

    logic         clk;
    logic         rst_n;
    logic         req0, req1, done0, done1;
    logic [N-1:0] d0, d1;
    logic         gnt0, gnt1, sel, busy, terr;
    logic [N-1:0] y;

    typedef struct packed {
        logic g0;
        logic g1;
        logic sel;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mux2_arbiter #(.N(N), .TIMEOUT(16)) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_req0       (req0),
        .i_req1       (req1),
        .i_done0      (done0),
        .i_done1      (done1),
        .i_d0         (d0),
        .i_d1         (d1),
        .o_gnt0       (gnt0),
        .o_gnt1       (gnt1),
        .o_sel        (sel),
        .o_y          (y),
        .o_busy       (busy),
        .o_timeout_err(terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic cyc(input logic rst, input logic r0, input logic r1,
                       input logic dn0, input logic dn1,
                       input logic eg0, input logic eg1, input logic esel, input logic eerr);
        exp_t e;
        rst_n = rst;
        req0  = r0;
        req1  = r1;
        done0 = dn0;
        done1 = dn1;
        sb.push_back('{g0: eg0, g1: eg1, sel: esel, err: eerr});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("gnt0", N'(gnt0), N'(e.g0));
        check("gnt1", N'(gnt1), N'(e.g1));
        check("sel", N'(sel), N'(e.sel));
        check("busy", N'(busy), N'(e.g0 | e.g1));
        check("timeout_err", N'(terr), N'(e.err));
        check("y", y, e.sel ? d1 : d0);
    endtask

    initial begin
        logic own;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        done0 = 1'b0;
        done1 = 1'b0;
        d0    = 32'h8000_0000;
        d1    = 32'h0000_0001;

        // Reset held with both requesting
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single request from requester 1
        cyc(1, 0, 1, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 1, 0, 1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);

        // Contention then DONE0 handoff with no idle bubble
        cyc(1, 1, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);

        // Forced release after 16 owned cycles; DONE1 of the non-owner is ignored
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 1, 0, (i == 5), 1, 0, 0, 0);
        end
        cyc(1, 1, 1, 0, 0, 0, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);

        // DONE0 coincident with the limit is a normal release
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 1, 0, 0, 1, 0, 0, 0);
        end
        cyc(1, 1, 1, 1, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);

        // Fairness: 12 grants, DONE on every third owned cycle
        cyc(1, 1, 1, 0, 0, 1, 0, 0, 0);
        for (int g = 0; g < 12; g++) begin
            own = logic'(g % 2);
            repeat (2) cyc(1, 1, 1, 0, 0, ~own, own, own, 0);
            if (g < 11) begin
                cyc(1, 1, 1, ~own, own, own, ~own, ~own, 0);
            end else begin
                cyc(1, 0, 0, ~own, own, 0, 0, 1, 0);
            end
        end

        // Reset while GNT1 has held for six cycles
        cyc(1, 0, 1, 0, 0, 0, 1, 1, 0);
        repeat (5) cyc(1, 0, 1, 0, 0, 0, 1, 1, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 1, 0, 0, 1, 0, 0, 0);
        end
        cyc(1, 1, 1, 0, 0, 0, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);

        // Y follows the selected operand combinationally; the other operand is ignored
        d1 = 32'hDEAD_BEEF;
        #1;
        check("y_comb_d1", y, 32'hDEAD_BEEF);
        d0 = 32'h1234_5678;
        #1;
        check("y_ignore_d0", y, 32'hDEAD_BEEF);
        cyc(1, 1, 0, 0, 0, 1, 0, 0, 0);
        d0 = 32'hA5A5_A5A5;
        #1;
        check("y_comb_d0", y, 32'hA5A5_A5A5);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
